// File: rtl/e_alloc.sv
// Round-robin slot allocator: offers one free one-hot slot at a time, tracks occupancy, flags protocol errors.
// Optional E_ALLOC_STATS_EN adds cnt_o, the registered population count of the occupancy vector.
module e_alloc #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         alloc_i,
  output logic         cand_vld_o,
  output logic [W-1:0] cand_o,
  input  logic         free_vld_i,
  input  logic [W-1:0] free_id_i,
  output logic         full_o,
  output logic         err_o,
  output logic [W-1:0] occ_o
`ifdef E_ALLOC_STATS_EN
  ,
  output logic [$clog2(W+1)-1:0] cnt_o
`endif
);

  // state  | meaning
  // SEARCH | scan registered occ/ptr for the next free slot
  // OFFER  | cand_o held stable until the consumer takes it
  // FULL   | every slot occupied, waiting for a release
  typedef enum logic [1:0] {SEARCH, OFFER, FULL} state_t;

  state_t       r_state;
  logic [W-1:0] r_occ;
  logic [W-1:0] r_ptr;
  logic [W-1:0] r_cand;
  logic         r_cand_vld;
  logic         r_full;
  logic         r_err;
  logic         r_arm;

  logic [W-1:0] w_cand;
  logic         w_found;
  logic         w_free_legal;
  logic         w_free_ok;
  logic         w_free_err;
  logic         w_alloc;
  logic [W-1:0] w_occ_nxt;

  // Scan downward from the bit below ptr, wrapping, so ptr's own bit is examined last.
  always_comb begin
    int v_ptr_idx;
    int v_idx;
    v_ptr_idx = 0;
    v_idx     = 0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int i = 0; i < W; i++) begin
      if (r_ptr[i]) v_ptr_idx = i;
    end
    for (int k = 1; k <= W; k++) begin
      v_idx = (v_ptr_idx + W - k) % W;
      if (!w_found && !r_occ[v_idx]) begin
        w_found       = 1'b1;
        w_cand[v_idx] = 1'b1;
      end
    end
  end

  assign w_alloc      = (r_state == OFFER) && alloc_i;
  assign w_free_legal = $onehot(free_id_i) && (|(free_id_i & r_occ)) &&
                        !((r_state == OFFER) && (free_id_i == r_cand));
  assign w_free_ok    = free_vld_i && w_free_legal;
  assign w_free_err   = free_vld_i && !w_free_legal;
  assign w_occ_nxt    = (r_occ & ~(w_free_ok ? free_id_i : '0)) | (w_alloc ? r_cand : '0);

  // r_arm holds off the first search one cycle after reset release.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= SEARCH;
      r_occ      <= '0;
      r_ptr      <= {1'b1, {(W-1){1'b0}}};
      r_cand     <= '0;
      r_cand_vld <= 1'b0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_arm      <= 1'b0;
    end else begin
      r_arm <= 1'b1;
      r_occ <= w_occ_nxt;
      if (w_free_err) r_err <= 1'b1;
      case (r_state)
        SEARCH: begin
          if (r_arm) begin
            if (w_found) begin
              r_state    <= OFFER;
              r_cand     <= w_cand;
              r_cand_vld <= 1'b1;
            end else begin
              r_state <= FULL;
              r_full  <= 1'b1;
            end
          end
        end
        OFFER: begin
          if (alloc_i) begin
            r_ptr      <= r_cand;
            r_cand     <= '0;
            r_cand_vld <= 1'b0;
            r_state    <= SEARCH;
          end
        end
        FULL: begin
          if (free_vld_i) begin
            r_state <= SEARCH;
            r_full  <= 1'b0;
          end
        end
        default: begin
          r_state    <= SEARCH;
          r_cand     <= '0;
          r_cand_vld <= 1'b0;
          r_full     <= 1'b0;
        end
      endcase
    end
  end

  assign cand_o     = r_cand;
  assign cand_vld_o = r_cand_vld;
  assign full_o     = r_full;
  assign err_o      = r_err;
  assign occ_o      = r_occ;

`ifdef E_ALLOC_STATS_EN
  localparam int CNT_W = $clog2(W+1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_cnt <= '0;
    else         r_cnt <= CNT_W'($countones(w_occ_nxt));
  end

  assign cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_e_alloc.sv
// Directed bench for e_alloc (W=4): allocation order, wrap-around, free handling, errors, reset.
module tb_e_alloc;

  logic       clk;
  logic       arst_n;
  logic       alloc_i;
  logic       cand_vld_o;
  logic [3:0] cand_o;
  logic       free_vld_i;
  logic [3:0] free_id_i;
  logic       full_o;
  logic       err_o;
  logic [3:0] occ_o;
`ifdef E_ALLOC_STATS_EN
  logic [2:0] cnt_o;
`endif

  int n_chk;
  int n_fail;

  e_alloc #(.W(4)) u_dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .alloc_i    (alloc_i),
    .cand_vld_o (cand_vld_o),
    .cand_o     (cand_o),
    .free_vld_i (free_vld_i),
    .free_id_i  (free_id_i),
    .full_o     (full_o),
    .err_o      (err_o),
    .occ_o      (occ_o)
`ifdef E_ALLOC_STATS_EN
    ,
    .cnt_o      (cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
`ifdef E_ALLOC_STATS_EN
    check(tag, 32'(cnt_o), exp);
`endif
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    arst_n = 1'b0;
    alloc_i = 1'b0;
    free_vld_i = 1'b0;
    free_id_i = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ", 32'(occ_o), 32'h0);
    check("rst_cand", 32'(cand_o), 32'h0);
    check("rst_vld", 32'(cand_vld_o), 32'h0);
    check("rst_full", 32'(full_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    chk_cnt("rst_cnt", 0);

    // alloc held high from release: first offer on the 2nd edge, then fill
    arst_n = 1'b1;
    alloc_i = 1'b1;
    tick(); check("arm_vld", 32'(cand_vld_o), 32'h0);
    tick(); check("c0_vld", 32'(cand_vld_o), 32'h1); check("c0", 32'(cand_o), 32'h4);
    tick(); check("a0_occ", 32'(occ_o), 32'h4); check("a0_vld", 32'(cand_vld_o), 32'h0);
    chk_cnt("cnt1", 1);
    tick(); check("c1", 32'(cand_o), 32'h2);
    tick(); check("a1_occ", 32'(occ_o), 32'h6); chk_cnt("cnt2", 2);
    tick(); check("c2", 32'(cand_o), 32'h1);
    tick(); check("a2_occ", 32'(occ_o), 32'h7); chk_cnt("cnt3", 3);
    tick(); check("c3", 32'(cand_o), 32'h8);
    tick(); check("a3_occ", 32'(occ_o), 32'hF); chk_cnt("cnt4", 4);
    tick(); check("full", 32'(full_o), 32'h1); check("full_vld", 32'(cand_vld_o), 32'h0);
    check("full_err", 32'(err_o), 32'h0);

    // release from FULL
    alloc_i = 1'b0; free_vld_i = 1'b1; free_id_i = 4'b0010;
    tick(); check("fr_occ", 32'(occ_o), 32'hD); check("fr_full", 32'(full_o), 32'h0);
    chk_cnt("cnt_fr", 3);
    free_vld_i = 1'b0;
    tick(); check("fr_cand", 32'(cand_o), 32'h2); check("fr_vld", 32'(cand_vld_o), 32'h1);

    // free during OFFER keeps the offer
    free_vld_i = 1'b1; free_id_i = 4'b0001;
    tick(); check("ret_occ", 32'(occ_o), 32'hC); check("ret_cand", 32'(cand_o), 32'h2);
    check("ret_vld", 32'(cand_vld_o), 32'h1);

    // simultaneous alloc of 0010 and free of 1000
    alloc_i = 1'b1; free_id_i = 4'b1000;
    tick(); check("sim_occ", 32'(occ_o), 32'h6); check("sim_vld", 32'(cand_vld_o), 32'h0);
    alloc_i = 1'b0; free_vld_i = 1'b0;
    tick(); check("sim_cand", 32'(cand_o), 32'h1);

    // freeing the current candidate is an error, sticky
    free_vld_i = 1'b1; free_id_i = 4'b0001;
    tick(); check("ec_err", 32'(err_o), 32'h1); check("ec_occ", 32'(occ_o), 32'h6);
    tick(); check("ec_err2", 32'(err_o), 32'h1); check("ec_occ2", 32'(occ_o), 32'h6);
    check("ec_cand", 32'(cand_o), 32'h1);
    free_vld_i = 1'b0;

    // reset mid-offer with alloc asserted: nothing is allocated
    alloc_i = 1'b1;
    #2;
    arst_n = 1'b0;
    #1;
    check("mr_occ", 32'(occ_o), 32'h0); check("mr_vld", 32'(cand_vld_o), 32'h0);
    check("mr_cand", 32'(cand_o), 32'h0); check("mr_err", 32'(err_o), 32'h0);
    tick(); check("mr_occ2", 32'(occ_o), 32'h0);

    // refill, then build occ=0110 with ptr=0100
    arst_n = 1'b1;
    repeat (10) tick();
    check("rf_full", 32'(full_o), 32'h1); check("rf_occ", 32'(occ_o), 32'hF);
    alloc_i = 1'b0; free_vld_i = 1'b1; free_id_i = 4'b0100;
    tick(); check("b_occ", 32'(occ_o), 32'hB);
    free_vld_i = 1'b0;
    tick(); check("b_cand", 32'(cand_o), 32'h4);
    free_vld_i = 1'b1; free_id_i = 4'b0001;
    tick();
    free_id_i = 4'b1000;
    tick(); check("b_occ2", 32'(occ_o), 32'h2); check("b_cand2", 32'(cand_o), 32'h4);
    free_vld_i = 1'b0; alloc_i = 1'b1;
    tick(); check("w_occ", 32'(occ_o), 32'h6);
    alloc_i = 1'b0;
    tick(); check("w_cand", 32'(cand_o), 32'h1);
    alloc_i = 1'b1;
    tick(); check("w_occ2", 32'(occ_o), 32'h7);
    alloc_i = 1'b0;
    tick(); check("w_wrap", 32'(cand_o), 32'h8);

    // non-one-hot free
    check("nh_err0", 32'(err_o), 32'h0);
    free_vld_i = 1'b1; free_id_i = 4'b0011;
    tick(); check("nh_err", 32'(err_o), 32'h1); check("nh_occ", 32'(occ_o), 32'h7);
    check("nh_cand", 32'(cand_o), 32'h8);
    free_vld_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
